// File: rtl/ones_frame_accumulator.sv
// ones_frame_accumulator
// Sums 2-bit one's-counter samples {y1,y0} over frames of FRAME_LEN accepted
// samples and holds each frame total behind a valid/ready handshake.
// Optional feature macro: ONES_ACC_THRESH_EN (adds registered thresh_hit = sum>=THRESH).
module ones_frame_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 5,
    parameter int THRESH    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             y1,
    input  logic             y0,
    output logic             in_ready,
    input  logic             frame_clr,
    output logic [SUM_W-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ONES_ACC_THRESH_EN
   ,output logic             thresh_hit
`endif
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    // Reject configurations where the frame total could overflow sum.
    generate
        if (FRAME_LEN < 2) begin : g_bad_len
            $error("ones_frame_accumulator: FRAME_LEN must be >= 2");
        end
        if ((2 ** SUM_W) <= (3 * FRAME_LEN)) begin : g_bad_w
            $error("ones_frame_accumulator: SUM_W too narrow for 3*FRAME_LEN");
        end
    endgenerate

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             thr_q, thr_d;

    logic [SUM_W-1:0] samp;
    logic [SUM_W-1:0] next_sum;
    logic             accept;

    assign samp     = {{(SUM_W-2){1'b0}}, y1, y0};
    assign next_sum = acc_q + samp;
    assign in_ready = (state_q == ACCUM);
    assign accept   = in_valid & in_ready;

    // State and datapath registers; rst overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            thr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            thr_q   <= thr_d;
        end
    end

    // Next-state and datapath update: accumulate in ACCUM, wait for handoff in HOLD.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        thr_d   = thr_q;
        unique case (state_q)
            ACCUM: begin
                if (frame_clr) begin
                    // Abort wins over a same-cycle sample, including the last one.
                    acc_d = '0;
                    cnt_d = '0;
                end else if (accept) begin
                    if (cnt_q == LAST_CNT) begin
                        sum_d   = next_sum;
                        acc_d   = '0;
                        cnt_d   = '0;
                        thr_d   = (32'(next_sum) >= 32'(THRESH));
                        state_d = HOLD;
                    end else begin
                        acc_d = next_sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // Drop or hand off the result; sum itself is kept for reference.
                if (frame_clr || out_ready) begin
                    thr_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign sum       = sum_q;
    assign out_valid = (state_q == HOLD);

`ifdef ONES_ACC_THRESH_EN
    assign thresh_hit = thr_q;
`else
    logic unused_thr;
    assign unused_thr = thr_q;
`endif

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Directed bench for ones_frame_accumulator (FRAME_LEN=8, SUM_W=5, THRESH=12).
// thresh_hit is connected and checked only when ONES_ACC_THRESH_EN is defined.
module tb_ones_frame_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       y1 = 1'b0;
    logic       y0 = 1'b0;
    logic       in_ready;
    logic       frame_clr = 1'b0;
    logic [4:0] sum;
    logic       out_valid;
    logic       out_ready = 1'b1;
`ifdef ONES_ACC_THRESH_EN
    logic       thresh_hit;
`endif

    int checks = 0;
    int errors = 0;

    ones_frame_accumulator #(.FRAME_LEN(8), .SUM_W(5), .THRESH(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .y1        (y1),
        .y0        (y0),
        .in_ready  (in_ready),
        .frame_clr (frame_clr),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ONES_ACC_THRESH_EN
       ,.thresh_hit(thresh_hit)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_thr(input string tag, input logic exp);
`ifdef ONES_ACC_THRESH_EN
        chk(tag, 32'(thresh_hit), 32'(exp));
`else
        if (exp === 1'bx) $display("unreachable %s", tag);
`endif
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed 8 samples (vals[1:0] first); optional idle cycle between samples.
    // Returns in the cycle after the 8th accept with in_valid low.
    task automatic run_frame(input logic [15:0] vals, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            {y1, y0} = vals[2*i +: 2];
            step();
            if (i < 7) begin
                chk("no_early_valid", 32'(out_valid), 0);
                if (gaps) begin
                    in_valid = 1'b0;
                    {y1, y0} = 2'd3;
                    step();
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        // 1: reset, then back-to-back 3s
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk_thr("rst_thr", 1'b0);
        out_ready = 1'b1;
        run_frame({8{2'd3}}, 1'b0);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_sum", 32'(sum), 24);
        chk("t1_in_ready", 32'(in_ready), 0);
        chk_thr("t1_thr", 1'b1);
        step();
        chk("t1_valid_drop", 32'(out_valid), 0);
        chk("t1_ready_back", 32'(in_ready), 1);
        chk_thr("t1_thr_clear", 1'b0);

        // 2: 0,1,2,3,0,1,2,3 with gaps
        run_frame({2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 1'b1);
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_sum", 32'(sum), 12);
        chk_thr("t2_thr", 1'b1);
        step();
        chk("t2_valid_drop", 32'(out_valid), 0);

        // 3: 1,1,1,1,0,0,0,1
        run_frame({2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1}, 1'b0);
        chk("t3_sum", 32'(sum), 5);
        chk_thr("t3_thr", 1'b0);
        step();

        // 4: backpressure for 5 cycles while upstream keeps offering data
        out_ready = 1'b0;
        run_frame({8{2'd2}}, 1'b0);
        in_valid = 1'b1;
        {y1, y0} = 2'd3;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(out_valid), 1);
            chk("t4_hold_sum", 32'(sum), 16);
            chk("t4_hold_ready", 32'(in_ready), 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("t4_release_valid", 32'(out_valid), 0);
        chk("t4_release_ready", 32'(in_ready), 1);
        chk("t4_sum_kept", 32'(sum), 16);

        // 5: partial frame then reset, no carry-over
        in_valid = 1'b1;
        {y1, y0} = 2'd3;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_ready", 32'(in_ready), 1);
        chk("t5_rst_sum", 32'(sum), 0);
        run_frame({8{2'd2}}, 1'b0);
        chk("t5_valid", 32'(out_valid), 1);
        chk("t5_sum", 32'(sum), 16);
        step();

        // 6: frame_clr on the 8th sample discards the frame
        in_valid = 1'b1;
        {y1, y0} = 2'd1;
        for (int i = 0; i < 7; i++) step();
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        in_valid = 1'b0;
        chk("t6_clr_no_valid", 32'(out_valid), 0);
        chk("t6_clr_ready", 32'(in_ready), 1);
        run_frame({8{2'd1}}, 1'b0);
        chk("t6_valid", 32'(out_valid), 1);
        chk("t6_sum", 32'(sum), 8);
        chk_thr("t6_thr", 1'b0);
        // frame_clr during HOLD with out_ready=1
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        chk("t6_hold_clr_valid", 32'(out_valid), 0);
        chk("t6_hold_clr_ready", 32'(in_ready), 1);
        // frame_clr during HOLD with out_ready=0, threshold result dropped
        out_ready = 1'b0;
        run_frame({8{2'd3}}, 1'b0);
        chk("t6b_valid", 32'(out_valid), 1);
        chk_thr("t6b_thr", 1'b1);
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
        chk("t6b_clr_valid", 32'(out_valid), 0);
        chk_thr("t6b_clr_thr", 1'b0);
        // counter restarted from zero after the drop
        run_frame({8{2'd0}}, 1'b0);
        chk("t6c_valid", 32'(out_valid), 1);
        chk("t6c_sum", 32'(sum), 0);
        out_ready = 1'b1;
        step();
        chk("t6c_valid_drop", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
